// File: rtl/des_cmd_pkg.sv
// des_cmd_pkg: command codes, status codes and sequencer state encoding shared with the DES wrapper.
package des_cmd_pkg;
    localparam logic [31:0] CMD_READ_SEED          = 32'd1;
    localparam logic [31:0] CMD_READ_POLY          = 32'd2;
    localparam logic [31:0] CMD_READ_INPUT_MASK    = 32'd3;
    localparam logic [31:0] CMD_READ_OUTPUT_MASK   = 32'd4;
    localparam logic [31:0] CMD_READ_COUNTER_LIMIT = 32'd5;
    localparam logic [31:0] CMD_START              = 32'd6;
    localparam logic [31:0] CMD_RESTART            = 32'd7;

    localparam logic [1:0] STAT_OK     = 2'd0;
    localparam logic [1:0] STAT_ABORT  = 2'd1;
    localparam logic [1:0] STAT_HS_TO  = 2'd2;
    localparam logic [1:0] STAT_RUN_TO = 2'd3;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_CMD_ASSERT  = 3'd1;
    localparam logic [2:0] S_CMD_RELEASE = 3'd2;
    localparam logic [2:0] S_WAIT_DONE   = 3'd3;
    localparam logic [2:0] S_CAPTURE     = 3'd4;
    localparam logic [2:0] S_RST_ASSERT  = 3'd5;
    localparam logic [2:0] S_RST_RELEASE = 3'd6;
    localparam logic [2:0] S_RESULT      = 3'd7;

    // Command index 0..5 maps onto SEED..START.
    function automatic logic [31:0] cmd_code(input logic [2:0] idx);
        return {29'd0, idx} + 32'd1;
    endfunction
endpackage

// File: rtl/des_cmd_handshake.sv
// des_cmd_handshake: four-phase cmd_valid/cmd_read master that holds cmd/data and times out each edge wait.
module des_cmd_handshake #(
    parameter int HS_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] cmd_in,
    input  logic [63:0] data_in,
    input  logic        cmd_read,
    output logic        cmd_valid,
    output logic [31:0] cmd,
    output logic [63:0] data,
    output logic        complete,
    output logic        timeout
);
    localparam int TW = $clog2(HS_TIMEOUT);
    localparam logic [1:0] P_IDLE = 2'd0, P_ASSERT = 2'd1, P_RELEASE = 2'd2;

    logic [1:0]    phase;
    logic [TW-1:0] timer;
    logic          progress, expired;

    assign cmd_valid = phase == P_ASSERT;
    assign progress  = phase == P_ASSERT ? cmd_read : !cmd_read;
    assign expired   = timer == TW'(HS_TIMEOUT - 1);
    assign complete  = phase == P_RELEASE && !cmd_read;
    assign timeout   = phase != P_IDLE && !progress && expired;

    // cmd/data stay put after release so the wrapper never sees a glitch while it still loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= P_IDLE;
            timer <= '0;
            cmd   <= '0;
            data  <= '0;
        end else if (start) begin
            phase <= P_ASSERT;
            timer <= '0;
            cmd   <= cmd_in;
            data  <= data_in;
        end else if (phase != P_IDLE) begin
            if (progress) begin
                phase <= phase == P_ASSERT ? P_RELEASE : P_IDLE;
                timer <= '0;
            end else if (expired) begin
                phase <= P_IDLE;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end
endmodule

// File: rtl/des_job_sequencer.sv
// des_job_sequencer: replays a job descriptor to the DES wrapper as SEED..START, waits for done,
// captures the counter, issues RESTART and returns the result on a valid/ready port.
module des_job_sequencer
    import des_cmd_pkg::*;
#(
    parameter int HS_TIMEOUT       = 64,
    parameter int RUN_TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [63:0] job_seed,
    input  logic [63:0] job_poly,
    input  logic [63:0] job_mask_i,
    input  logic [63:0] job_mask_o,
    input  logic [63:0] job_limit,
    input  logic        abort,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_counter,
    output logic [1:0]  res_status,
    output logic        busy,
    output logic [31:0] cmd,
    output logic        cmd_valid,
    output logic [31:0] data_upper,
    output logic [31:0] data_lower,
    input  logic        cmd_read,
    input  logic        done,
    input  logic [63:0] counter
);
    logic [2:0]                  state, cmd_idx;
    logic [63:0]                 poly, mask_i, mask_o, limit;
    logic [RUN_TIMEOUT_BITS-1:0] run_cnt;
    logic                        accept, hs_start, hs_complete, hs_timeout;
    logic [31:0]                 hs_cmd;
    logic [63:0]                 hs_data, hs_out;

    assign accept = state == S_IDLE && job_valid && job_ready;
    assign busy   = state != S_IDLE && state != S_RESULT;
    assign {data_upper, data_lower} = hs_out;

    // The seed goes straight from the port into the handshake on acceptance, so it needs no copy here.
    always_comb begin
        hs_start = accept || (state == S_CMD_RELEASE && hs_complete && cmd_idx != 3'd5) ||
                   (state == S_WAIT_DONE && !done && (abort || &run_cnt)) || state == S_CAPTURE;
        hs_cmd   = state == S_IDLE ? CMD_READ_SEED :
                   state == S_CMD_RELEASE ? cmd_code(cmd_idx + 3'd1) : CMD_RESTART;
        hs_data  = state == S_IDLE ? job_seed :
                   state != S_CMD_RELEASE ? 64'd0 :
                   cmd_idx == 3'd0 ? poly :
                   cmd_idx == 3'd1 ? mask_i :
                   cmd_idx == 3'd2 ? mask_o :
                   cmd_idx == 3'd3 ? limit : 64'd0;
    end

    des_cmd_handshake #(.HS_TIMEOUT(HS_TIMEOUT)) u_hs (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (hs_start),
        .cmd_in   (hs_cmd),
        .data_in  (hs_data),
        .cmd_read (cmd_read),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .data     (hs_out),
        .complete (hs_complete),
        .timeout  (hs_timeout)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            poly   <= job_poly;
            mask_i <= job_mask_i;
            mask_o <= job_mask_o;
            limit  <= job_limit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            job_ready   <= 1'b1;
            res_valid   <= 1'b0;
            res_counter <= '0;
            res_status  <= STAT_OK;
            cmd_idx     <= '0;
            run_cnt     <= '0;
        end else if (hs_timeout) begin
            state       <= S_RESULT;
            res_valid   <= 1'b1;
            res_status  <= STAT_HS_TO;
            res_counter <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    cmd_idx     <= '0;
                    job_ready   <= 1'b0;
                    res_counter <= '0;
                    res_status  <= STAT_OK;
                    state       <= S_CMD_ASSERT;
                end
                S_CMD_ASSERT: if (cmd_read) state <= S_CMD_RELEASE;
                S_CMD_RELEASE: if (hs_complete) begin
                    if (cmd_idx == 3'd5) begin
                        run_cnt <= '0;
                        state   <= S_WAIT_DONE;
                    end else begin
                        cmd_idx <= cmd_idx + 3'd1;
                        state   <= S_CMD_ASSERT;
                    end
                end
                // done outranks abort and the run-timeout when they coincide.
                S_WAIT_DONE: begin
                    run_cnt <= run_cnt + RUN_TIMEOUT_BITS'(1);
                    if (done) begin
                        state <= S_CAPTURE;
                    end else if (abort) begin
                        res_status <= STAT_ABORT;
                        state      <= S_RST_ASSERT;
                    end else if (&run_cnt) begin
                        res_status <= STAT_RUN_TO;
                        state      <= S_RST_ASSERT;
                    end
                end
                S_CAPTURE: begin
                    res_counter <= counter;
                    state       <= S_RST_ASSERT;
                end
                S_RST_ASSERT: if (cmd_read) state <= S_RST_RELEASE;
                S_RST_RELEASE: if (hs_complete) begin
                    res_valid <= 1'b1;
                    state     <= S_RESULT;
                end
                default: if (res_ready) begin
                    res_valid <= 1'b0;
                    job_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
